// File: rtl/cnt_seq_monitor_if.sv
// Observation bus between the mod-N counter output and its sequence monitor.
// The master side supplies samples; the slave (monitor) returns status flags.
interface cnt_seq_monitor_if #(
  parameter int W  = 4,
  parameter int EW = 8
);
  logic          en;
  logic [W-1:0]  cntQ_in;
  logic          locked;
  logic          dir_det;
  logic          wrap;
  logic          dir_chg;
  logic          err;
  logic [EW-1:0] err_cnt;

  modport master (
    output en, cntQ_in,
    input  locked, dir_det, wrap, dir_chg, err, err_cnt
  );

  modport slave (
    input  en, cntQ_in,
    output locked, dir_det, wrap, dir_chg, err, err_cnt
  );
endinterface

// File: rtl/cnt_seq_monitor.sv
// Receive-side checker for a mod-MOD up/down counter: infers direction,
// flags wraps, reversals and illegal steps, and keeps a saturating error count.
//
//   state | meaning
//   IDLE  | no reference sample yet
//   ACQ   | have prev, waiting for a legal step to infer direction
//   LOCK  | direction known, tracking each step
module cnt_seq_monitor #(
  parameter int MOD = 10,
  parameter int W   = 4,
  parameter int EW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  cnt_seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  state_t        state;
  logic [W-1:0]  prev;
  logic [W-1:0]  nxt_up;
  logic [W-1:0]  nxt_dn;
  logic          out_of_range;
  logic          wrap_up;
  logic          wrap_dn;
  logic          is_up;
  logic          is_dn;

  assign nxt_up       = (prev == MAX) ? '0 : prev + W'(1);
  assign nxt_dn       = (prev == '0) ? MAX : prev - W'(1);
  assign out_of_range = ({1'b0, mon.cntQ_in} >= (W+1)'(MOD));
  assign is_up        = (mon.cntQ_in == nxt_up);
  assign is_dn        = (mon.cntQ_in == nxt_dn);
  assign wrap_up      = (prev == MAX) && (mon.cntQ_in == '0);
  assign wrap_dn      = (prev == '0) && (mon.cntQ_in == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev        <= '0;
      mon.locked  <= 1'b0;
      mon.dir_det <= 1'b0;
      mon.wrap    <= 1'b0;
      mon.dir_chg <= 1'b0;
      mon.err     <= 1'b0;
      mon.err_cnt <= '0;
    end else begin
      mon.wrap    <= 1'b0;
      mon.dir_chg <= 1'b0;
      mon.err     <= 1'b0;
      if (mon.en) begin
        if (out_of_range) begin
          // prev is left alone; IDLE reloads it on the next good sample
          state      <= IDLE;
          mon.locked <= 1'b0;
          mon.err    <= 1'b1;
          if (mon.err_cnt != '1) mon.err_cnt <= mon.err_cnt + EW'(1);
        end else begin
          prev <= mon.cntQ_in;
          case (state)
            IDLE: begin
              state <= ACQ;
            end
            ACQ: begin
              if (is_up) begin
                state       <= LOCK;
                mon.locked  <= 1'b1;
                mon.dir_det <= 1'b0;
                mon.wrap    <= wrap_up;
              end else if (is_dn) begin
                state       <= LOCK;
                mon.locked  <= 1'b1;
                mon.dir_det <= 1'b1;
                mon.wrap    <= wrap_dn;
              end else begin
                mon.err <= 1'b1;
                if (mon.err_cnt != '1) mon.err_cnt <= mon.err_cnt + EW'(1);
              end
            end
            LOCK: begin
              if (is_up || is_dn) begin
                mon.dir_det <= is_dn;
                mon.dir_chg <= (is_dn != mon.dir_det);
                mon.wrap    <= is_up ? wrap_up : wrap_dn;
              end else begin
                state      <= ACQ;
                mon.locked <= 1'b0;
                mon.err    <= 1'b1;
                if (mon.err_cnt != '1) mon.err_cnt <= mon.err_cnt + EW'(1);
              end
            end
            default: begin
              state      <= IDLE;
              mon.locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
